decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode stage of the LC-3b pipeline, directly downstream of fetch.
- Owns the DE pipeline latch, which captures fetch's NPC/IR/valid on ld_de.
- Owns the 8x16 register file and the N/Z/P condition-code register.
- Detects data and CC dependencies, producing dep_stall and v_de_br_stall back to fetch, and loads the AGEX latch.

Parameters:
- REG_COUNT, 8, number of architectural registers; index width is 3 bits.
- CC_RESET, 3'b010, N/Z/P value after reset (Z set).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- ld_de  input  1  load DE latch (from fetch; low during dep/mem stall)
- fe_npc  input  16  PC+2 from fetch
- fe_ir  input  16  instruction from fetch
- fe_v  input  1  fetch valid
- ld_agex  input  1  load AGEX latch (low during mem stall)
- v_agex_ld_reg  input  1  valid AGEX instr writes a register
- agex_drid_in  input  3  AGEX destination
- v_agex_ld_cc  input  1  valid AGEX instr sets CC
- v_mem_ld_reg  input  1  valid MEM instr writes a register
- mem_drid_in  input  3  MEM destination
- v_mem_ld_cc  input  1  valid MEM instr sets CC
- sr_ld_reg  input  1  SR-stage register write enable
- sr_drid  input  3  SR write index
- sr_data  input  16  SR write data
- sr_ld_cc  input  1  SR-stage CC update enable
- dep_stall  output  1  DE instruction waits on an in-flight result
- v_de_br_stall  output  1  valid control-flow instruction in DE
- agex_npc  output  16  AGEX latch NPC
- agex_ir  output  16  AGEX latch IR
- agex_sr1  output  16  AGEX latch SR1 value
- agex_sr2  output  16  AGEX latch SR2/store-source value
- agex_cc  output  3  AGEX latch N/Z/P
- agex_drid  output  3  AGEX latch destination
- agex_ld_reg  output  1  AGEX latch register-write flag
- agex_ld_cc  output  1  AGEX latch CC-write flag
- agex_v  output  1  AGEX latch valid

Behaviour:
- Reset (async, immediate):
  - DE latch (npc, ir, v) = 0.
  - All AGEX latch outputs = 0, except agex_cc = CC_RESET.
  - All registers R0–R7 = 0; CC = CC_RESET.
  - Reset mid-stall discards all in-flight state.
- DE latch: at posedge, if ld_de, de_npc <= fe_npc, de_ir <= fe_ir, de_v <= fe_v; otherwise it holds.
- Decode fields:
  - op = de_ir[15:12].
  - sr1 = de_ir[8:6].
  - sr2 = de_ir[11:9] for STB (0011) and STW (0111); otherwise de_ir[2:0].
- Source usage:
  - uses_sr1: ADD, AND, XOR, SHF, LDB, LDW, STB, STW, JMP, and JSR when de_ir[11] = 0.
  - uses_sr2: ADD/AND/XOR when de_ir[5] = 0, and STB/STW.
  - uses_cc: BR (0000).
- Destination and CC flags:
  - drid = 7 for JSR (0100) and TRAP (1111); otherwise de_ir[11:9].
  - ld_reg: ADD, AND, XOR, SHF, LDB, LDW, LEA, JSR, TRAP.
  - ld_cc: ADD, AND, XOR, SHF, LDB, LDW.
- Register file:
  - Write at posedge when sr_ld_reg.
  - Reads are combinational with SR bypass: if sr_ld_reg and sr_drid equals the read index, sr_data is returned.
- CC register:
  - At posedge when sr_ld_cc: N = sr_data[15], Z = (sr_data == 0), P = !N && !Z.
  - Same-cycle bypass to the agex_cc input when sr_ld_cc.
- dep_stall (combinational) = de_v && (sr1 hazard || sr2 hazard || cc hazard):
  - sr1/sr2 hazard: the source is used and matches a destination with v_agex_ld_reg/agex_drid_in, or with v_mem_ld_reg/mem_drid_in.
  - cc hazard: uses_cc && (v_agex_ld_cc || v_mem_ld_cc).
  - SR-stage writes never stall; they are covered by the bypass.
- v_de_br_stall (combinational) = de_v && op ∈ {BR, JMP, JSR, TRAP}.
- AGEX latch at posedge when ld_agex:
  - Loads npc, ir, sr1/sr2 values, cc, drid, ld_reg, ld_cc.
  - agex_v <= de_v && !dep_stall.
  - When !ld_agex, all AGEX fields hold.
- Simultaneous events:
  - dep_stall with ld_agex: a bubble (agex_v = 0) enters AGEX while DE holds, since fetch drops ld_de.
  - ld_de during an SR write: the write and the latch load both occur.
- Latency: one cycle from DE latch to AGEX latch when there is no stall.
- R0 is an ordinary register (LC-3b has no hardwired zero).

Test Plan:
- Reset asserted mid-run -> all outputs 0 immediately, agex_cc = 3'b010; after release, R3 reads 0.
- SR writes R1 = 16'h0005; DE holds ADD R2,R1,R1 (16'h1441) with fe_v = 1 -> agex_sr1 = agex_sr2 = 16'h0005, agex_drid = 2, agex_ld_reg = 1, agex_ld_cc = 1, agex_v = 1 one cycle after the DE load.
- DE holds ADD R2,R1,R1 with v_agex_ld_reg = 1, agex_drid_in = 1 -> dep_stall = 1, agex_v = 0; deassert the hazard -> dep_stall = 0 and valid issue next edge.
- Same-cycle bypass: sr_ld_reg = 1, sr_drid = 1, sr_data = 16'hBEEF while DE holds STW R1,R4,#0 (16'h7300) -> agex_sr2 = 16'hBEEF, dep_stall = 0.
- BRz in DE with v_mem_ld_cc = 1 -> dep_stall = 1 and v_de_br_stall = 1; then sr_ld_cc with sr_data = 16'h8000 -> agex_cc = 3'b100.
- ld_agex = 0 for 3 cycles with changing DE contents -> all AGEX outputs hold; JSR in DE -> agex_drid = 7.

Source files
------------

// File: rtl/decode_stage.sv
// LC-3b decode stage: DE pipeline latch, 8x16 register file with write-back
// bypass, N/Z/P condition codes, hazard detection and the AGEX pipeline latch.
module decode_stage #(
    parameter int         REG_COUNT = 8,
    parameter logic [2:0] CC_RESET  = 3'b010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_de,
    input  logic [15:0] fe_npc,
    input  logic [15:0] fe_ir,
    input  logic        fe_v,
    input  logic        ld_agex,
    input  logic        v_agex_ld_reg,
    input  logic [2:0]  agex_drid_in,
    input  logic        v_agex_ld_cc,
    input  logic        v_mem_ld_reg,
    input  logic [2:0]  mem_drid_in,
    input  logic        v_mem_ld_cc,
    input  logic        sr_ld_reg,
    input  logic [2:0]  sr_drid,
    input  logic [15:0] sr_data,
    input  logic        sr_ld_cc,
    output logic        dep_stall,
    output logic        v_de_br_stall,
    output logic [15:0] agex_npc,
    output logic [15:0] agex_ir,
    output logic [15:0] agex_sr1,
    output logic [15:0] agex_sr2,
    output logic [2:0]  agex_cc,
    output logic [2:0]  agex_drid,
    output logic        agex_ld_reg,
    output logic        agex_ld_cc,
    output logic        agex_v
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDW  = 4'b0110;
    localparam logic [3:0] OP_STW  = 4'b0111;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_SHF  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // DE latch
    logic [15:0] de_npc_q, de_npc_d;
    logic [15:0] de_ir_q, de_ir_d;
    logic        de_v_q, de_v_d;

    always_comb begin
        de_npc_d = de_npc_q;
        de_ir_d  = de_ir_q;
        de_v_d   = de_v_q;
        if (ld_de) begin
            de_npc_d = fe_npc;
            de_ir_d  = fe_ir;
            de_v_d   = fe_v;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de_npc_q <= '0;
            de_ir_q  <= '0;
            de_v_q   <= 1'b0;
        end else begin
            de_npc_q <= de_npc_d;
            de_ir_q  <= de_ir_d;
            de_v_q   <= de_v_d;
        end
    end

    // Instruction decode
    logic [3:0] op;
    logic [2:0] sr1_idx, sr2_idx, drid;
    logic       uses_sr1, uses_sr2, uses_cc, ld_reg, ld_cc, is_ctrl;

    always_comb begin
        op       = de_ir_q[15:12];
        sr1_idx  = de_ir_q[8:6];
        sr2_idx  = de_ir_q[2:0];
        drid     = de_ir_q[11:9];
        uses_sr1 = 1'b0;
        uses_sr2 = 1'b0;
        uses_cc  = 1'b0;
        ld_reg   = 1'b0;
        ld_cc    = 1'b0;
        is_ctrl  = 1'b0;
        case (op)
            OP_ADD, OP_AND, OP_XOR: begin
                uses_sr1 = 1'b1;
                uses_sr2 = ~de_ir_q[5];
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
            end
            OP_SHF, OP_LDB, OP_LDW: begin
                uses_sr1 = 1'b1;
                ld_reg   = 1'b1;
                ld_cc    = 1'b1;
            end
            OP_STB, OP_STW: begin
                // Stores read their data register from the DR field.
                sr2_idx  = de_ir_q[11:9];
                uses_sr1 = 1'b1;
                uses_sr2 = 1'b1;
            end
            OP_BR: begin
                uses_cc = 1'b1;
                is_ctrl = 1'b1;
            end
            OP_JMP: begin
                uses_sr1 = 1'b1;
                is_ctrl  = 1'b1;
            end
            OP_JSR: begin
                uses_sr1 = ~de_ir_q[11];
                drid     = 3'd7;
                ld_reg   = 1'b1;
                is_ctrl  = 1'b1;
            end
            OP_TRAP: begin
                drid    = 3'd7;
                ld_reg  = 1'b1;
                is_ctrl = 1'b1;
            end
            OP_LEA: begin
                ld_reg = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Register file and condition codes
    logic [15:0] regs_q [REG_COUNT];
    logic [15:0] regs_d [REG_COUNT];
    logic [2:0]  cc_q, cc_d, sr_cc;
    logic [15:0] sr1_val, sr2_val;

    always_comb begin
        regs_d = regs_q;
        if (sr_ld_reg)
            regs_d[sr_drid] = sr_data;
    end

    always_comb begin
        sr_cc = {sr_data[15], sr_data == 16'h0000, ~sr_data[15] && (sr_data != 16'h0000)};
        cc_d  = sr_ld_cc ? sr_cc : cc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs_q[i] <= '0;
            cc_q <= CC_RESET;
        end else begin
            regs_q <= regs_d;
            cc_q   <= cc_d;
        end
    end

    // Write-back in the same cycle is forwarded so the SR stage never stalls.
    always_comb begin
        sr1_val = (sr_ld_reg && (sr_drid == sr1_idx)) ? sr_data : regs_q[sr1_idx];
        sr2_val = (sr_ld_reg && (sr_drid == sr2_idx)) ? sr_data : regs_q[sr2_idx];
    end

    // Hazard detection
    logic sr1_haz, sr2_haz, cc_haz;

    always_comb begin
        sr1_haz = uses_sr1 && ((v_agex_ld_reg && (agex_drid_in == sr1_idx)) ||
                               (v_mem_ld_reg  && (mem_drid_in  == sr1_idx)));
        sr2_haz = uses_sr2 && ((v_agex_ld_reg && (agex_drid_in == sr2_idx)) ||
                               (v_mem_ld_reg  && (mem_drid_in  == sr2_idx)));
        cc_haz  = uses_cc && (v_agex_ld_cc || v_mem_ld_cc);
    end

    assign dep_stall     = de_v_q && (sr1_haz || sr2_haz || cc_haz);
    assign v_de_br_stall = de_v_q && is_ctrl;

    // AGEX latch
    logic [15:0] agex_npc_q, agex_npc_d, agex_ir_q, agex_ir_d;
    logic [15:0] agex_sr1_q, agex_sr1_d, agex_sr2_q, agex_sr2_d;
    logic [2:0]  agex_cc_q, agex_cc_d, agex_drid_q, agex_drid_d;
    logic        agex_ld_reg_q, agex_ld_reg_d, agex_ld_cc_q, agex_ld_cc_d;
    logic        agex_v_q, agex_v_d;

    always_comb begin
        agex_npc_d    = agex_npc_q;
        agex_ir_d     = agex_ir_q;
        agex_sr1_d    = agex_sr1_q;
        agex_sr2_d    = agex_sr2_q;
        agex_cc_d     = agex_cc_q;
        agex_drid_d   = agex_drid_q;
        agex_ld_reg_d = agex_ld_reg_q;
        agex_ld_cc_d  = agex_ld_cc_q;
        agex_v_d      = agex_v_q;
        if (ld_agex) begin
            agex_npc_d    = de_npc_q;
            agex_ir_d     = de_ir_q;
            agex_sr1_d    = sr1_val;
            agex_sr2_d    = sr2_val;
            agex_cc_d     = cc_d;
            agex_drid_d   = drid;
            agex_ld_reg_d = ld_reg;
            agex_ld_cc_d  = ld_cc;
            agex_v_d      = de_v_q && !dep_stall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agex_npc_q    <= '0;
            agex_ir_q     <= '0;
            agex_sr1_q    <= '0;
            agex_sr2_q    <= '0;
            agex_cc_q     <= CC_RESET;
            agex_drid_q   <= '0;
            agex_ld_reg_q <= 1'b0;
            agex_ld_cc_q  <= 1'b0;
            agex_v_q      <= 1'b0;
        end else begin
            agex_npc_q    <= agex_npc_d;
            agex_ir_q     <= agex_ir_d;
            agex_sr1_q    <= agex_sr1_d;
            agex_sr2_q    <= agex_sr2_d;
            agex_cc_q     <= agex_cc_d;
            agex_drid_q   <= agex_drid_d;
            agex_ld_reg_q <= agex_ld_reg_d;
            agex_ld_cc_q  <= agex_ld_cc_d;
            agex_v_q      <= agex_v_d;
        end
    end

    assign agex_npc    = agex_npc_q;
    assign agex_ir     = agex_ir_q;
    assign agex_sr1    = agex_sr1_q;
    assign agex_sr2    = agex_sr2_q;
    assign agex_cc     = agex_cc_q;
    assign agex_drid   = agex_drid_q;
    assign agex_ld_reg = agex_ld_reg_q;
    assign agex_ld_cc  = agex_ld_cc_q;
    assign agex_v      = agex_v_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table of single-instruction decodes
// plus hand-written stall, hold and mid-run reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_de, fe_v, ld_agex;
    logic [15:0] fe_npc, fe_ir;
    logic        v_agex_ld_reg, v_agex_ld_cc, v_mem_ld_reg, v_mem_ld_cc;
    logic [2:0]  agex_drid_in, mem_drid_in, sr_drid;
    logic        sr_ld_reg, sr_ld_cc;
    logic [15:0] sr_data;
    logic        dep_stall, v_de_br_stall;
    logic [15:0] agex_npc, agex_ir, agex_sr1, agex_sr2;
    logic [2:0]  agex_cc, agex_drid;
    logic        agex_ld_reg, agex_ld_cc, agex_v;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .ld_de(ld_de), .fe_npc(fe_npc), .fe_ir(fe_ir),
        .fe_v(fe_v), .ld_agex(ld_agex), .v_agex_ld_reg(v_agex_ld_reg),
        .agex_drid_in(agex_drid_in), .v_agex_ld_cc(v_agex_ld_cc),
        .v_mem_ld_reg(v_mem_ld_reg), .mem_drid_in(mem_drid_in),
        .v_mem_ld_cc(v_mem_ld_cc), .sr_ld_reg(sr_ld_reg), .sr_drid(sr_drid),
        .sr_data(sr_data), .sr_ld_cc(sr_ld_cc), .dep_stall(dep_stall),
        .v_de_br_stall(v_de_br_stall), .agex_npc(agex_npc), .agex_ir(agex_ir),
        .agex_sr1(agex_sr1), .agex_sr2(agex_sr2), .agex_cc(agex_cc),
        .agex_drid(agex_drid), .agex_ld_reg(agex_ld_reg), .agex_ld_cc(agex_ld_cc),
        .agex_v(agex_v)
    );

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic        fv;
        logic        ald;
        logic [2:0]  adr;
        logic        alc;
        logic        mld;
        logic [2:0]  mdr;
        logic        mlc;
        logic        sld;
        logic [2:0]  sdr;
        logic [15:0] sdat;
        logic        slc;
        logic        e_dep;
        logic        e_br;
        logic [15:0] e_sr1;
        logic [15:0] e_sr2;
        logic [2:0]  e_cc;
        logic [2:0]  e_drid;
        logic        e_ldr;
        logic        e_ldc;
        logic        e_v;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_agex(input string tag, input logic [15:0] npc, input logic [15:0] ir,
                            input logic [15:0] s1, input logic [15:0] s2, input logic [2:0] cc,
                            input logic [2:0] dr, input logic ldr, input logic ldc, input logic v);
        chk({tag, ".agex_npc"}, agex_npc, npc);
        chk({tag, ".agex_ir"}, agex_ir, ir);
        chk({tag, ".agex_sr1"}, agex_sr1, s1);
        chk({tag, ".agex_sr2"}, agex_sr2, s2);
        chk({tag, ".agex_cc"}, {13'd0, agex_cc}, {13'd0, cc});
        chk({tag, ".agex_drid"}, {13'd0, agex_drid}, {13'd0, dr});
        chk({tag, ".agex_ld_reg"}, {15'd0, agex_ld_reg}, {15'd0, ldr});
        chk({tag, ".agex_ld_cc"}, {15'd0, agex_ld_cc}, {15'd0, ldc});
        chk({tag, ".agex_v"}, {15'd0, agex_v}, {15'd0, v});
    endtask

    task automatic idle_inputs();
        ld_de = 1'b0; fe_v = 1'b0; fe_npc = '0; fe_ir = '0; ld_agex = 1'b0;
        v_agex_ld_reg = 1'b0; agex_drid_in = '0; v_agex_ld_cc = 1'b0;
        v_mem_ld_reg = 1'b0; mem_drid_in = '0; v_mem_ld_cc = 1'b0;
        sr_ld_reg = 1'b0; sr_drid = '0; sr_data = '0; sr_ld_cc = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_de(input logic [15:0] ir, input logic [15:0] npc, input logic v);
        idle_inputs();
        ld_de = 1'b1; fe_ir = ir; fe_npc = npc; fe_v = v;
        tick();
        idle_inputs();
    endtask

    task automatic apply_vec(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        load_de(vecs[i].ir, vecs[i].npc, vecs[i].fv);
        ld_agex = 1'b1;
        v_agex_ld_reg = vecs[i].ald; agex_drid_in = vecs[i].adr; v_agex_ld_cc = vecs[i].alc;
        v_mem_ld_reg = vecs[i].mld; mem_drid_in = vecs[i].mdr; v_mem_ld_cc = vecs[i].mlc;
        sr_ld_reg = vecs[i].sld; sr_drid = vecs[i].sdr; sr_data = vecs[i].sdat;
        sr_ld_cc = vecs[i].slc;
        #1;
        chk({tag, ".dep_stall"}, {15'd0, dep_stall}, {15'd0, vecs[i].e_dep});
        chk({tag, ".v_de_br_stall"}, {15'd0, v_de_br_stall}, {15'd0, vecs[i].e_br});
        tick();
        idle_inputs();
        chk_agex(tag, vecs[i].npc, vecs[i].ir, vecs[i].e_sr1, vecs[i].e_sr2, vecs[i].e_cc,
                 vecs[i].e_drid, vecs[i].e_ldr, vecs[i].e_ldc, vecs[i].e_v);
        $display("%s ir=%h dep=%b br=%b agex_v=%b sr1=%h sr2=%h cc=%b", tag, vecs[i].ir,
                 vecs[i].e_dep, vecs[i].e_br, agex_v, agex_sr1, agex_sr2, agex_cc);
    endtask

    initial begin
        // Registers are preloaded to R_i = 16'h1111 * i; CC starts at 3'b010.
        vecs[0]  = '{16'h1441, 16'h3000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 16'h1111, 16'h1111, 3'b010, 3'd2, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{16'h1441, 16'h3002, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b0, 16'h1111, 16'h1111, 3'b010, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{16'h14E1, 16'h3004, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 16'h3333, 16'h1111, 3'b010, 3'd2, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{16'h1441, 16'h3006, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b0, 16'h1111, 16'h1111, 3'b010, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{16'h7300, 16'h3008, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 16'hBEEF, 1'b0,
                     1'b0, 1'b0, 16'h4444, 16'hBEEF, 3'b010, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'h0405, 16'h300A, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b1, 16'h0000, 16'h5555, 3'b010, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h0405, 16'h300C, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h8000, 1'b1,
                     1'b0, 1'b1, 16'h0000, 16'h5555, 3'b100, 3'd2, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{16'h4802, 16'h300E, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b1, 16'h0000, 16'h2222, 3'b100, 3'd7, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h40C0, 16'h3010, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b1, 16'h3333, 16'h0000, 3'b100, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'hF025, 16'h3012, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b1, 16'h0000, 16'h5555, 3'b100, 3'd7, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{16'h9DC2, 16'h3014, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b0, 16'h7777, 16'h2222, 3'b100, 3'd6, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{16'hEA03, 16'h3016, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 16'h0000, 16'h3333, 3'b100, 3'd5, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{16'h6981, 16'h3018, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd6, 16'h1234, 1'b1,
                     1'b0, 1'b0, 16'h1234, 16'hBEEF, 3'b001, 3'd4, 1'b1, 1'b1, 1'b1};
        vecs[13] = '{16'h1441, 16'h301A, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 16'hBEEF, 16'hBEEF, 3'b001, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{16'h5200, 16'h301C, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 16'h00FF, 1'b0,
                     1'b0, 1'b0, 16'h00FF, 16'h00FF, 3'b001, 3'd1, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{16'hD782, 16'h301E, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b0, 1'b0, 16'h1234, 16'h2222, 3'b001, 3'd3, 1'b1, 1'b1, 1'b1};
        vecs[16] = '{16'h3580, 16'h3020, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b0, 16'h1234, 16'h2222, 3'b001, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{16'h0E00, 16'h3022, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0,
                     1'b1, 1'b1, 16'h00FF, 16'h00FF, 3'b001, 3'd7, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst.dep_stall", {15'd0, dep_stall}, 16'd0);
        chk_agex("rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0);
        $display("reset: agex_v=%b agex_cc=%b", agex_v, agex_cc);
        tick();
        reset = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) begin
            sr_ld_reg = 1'b1; sr_drid = 3'(r); sr_data = 16'h1111 * 16'(r);
            tick();
        end
        idle_inputs();

        for (int i = 0; i < NV; i++)
            apply_vec(i);

        // Hazard held for two cycles: bubbles enter AGEX, then the ADD issues.
        load_de(16'h1441, 16'h3100, 1'b1);
        for (int c = 0; c < 2; c++) begin
            ld_agex = 1'b1; v_agex_ld_reg = 1'b1; agex_drid_in = 3'd1;
            #1;
            chk($sformatf("haz%0d.dep_stall", c), {15'd0, dep_stall}, 16'd1);
            tick();
            chk($sformatf("haz%0d.agex_v", c), {15'd0, agex_v}, 16'd0);
            $display("hazard cycle %0d: dep_stall=%b agex_v=%b", c, dep_stall, agex_v);
        end
        idle_inputs();
        ld_agex = 1'b1;
        #1;
        chk("haz_clr.dep_stall", {15'd0, dep_stall}, 16'd0);
        tick();
        idle_inputs();
        chk_agex("haz_clr", 16'h3100, 16'h1441, 16'hBEEF, 16'hBEEF, 3'b001, 3'd2, 1'b1, 1'b1, 1'b1);
        $display("hazard cleared: agex_v=%b agex_sr1=%h", agex_v, agex_sr1);

        // AGEX holds while ld_agex is low even as DE keeps changing.
        load_de(16'h0E00, 16'h3022, 1'b1);
        ld_agex = 1'b1;
        v_agex_ld_cc = 1'b1;
        tick();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            ld_de = 1'b1; fe_v = 1'b1; fe_npc = 16'h3200 + 16'(2 * c);
            fe_ir = (c == 2) ? 16'h4802 : 16'h1441 + 16'(c);
            v_agex_ld_reg = 1'b1; agex_drid_in = 3'd1;
            tick();
            idle_inputs();
            chk_agex($sformatf("hold%0d", c), vecs[17].npc, vecs[17].ir, vecs[17].e_sr1,
                     vecs[17].e_sr2, vecs[17].e_cc, vecs[17].e_drid, vecs[17].e_ldr,
                     vecs[17].e_ldc, vecs[17].e_v);
            $display("hold cycle %0d: agex_ir=%h agex_v=%b", c, agex_ir, agex_v);
        end
        ld_agex = 1'b1;
        tick();
        idle_inputs();
        chk_agex("jsr", 16'h3204, 16'h4802, 16'h00FF, 16'h2222, 3'b001, 3'd7, 1'b1, 1'b0, 1'b1);
        $display("jsr after hold: agex_drid=%0d agex_v=%b", agex_drid, agex_v);

        // Asynchronous reset mid-cycle with a valid instruction in flight.
        load_de(16'h1441, 16'h3300, 1'b1);
        ld_agex = 1'b1; v_mem_ld_reg = 1'b1; mem_drid_in = 3'd1;
        #1;
        reset = 1'b1;
        #1;
        chk("mrst.dep_stall", {15'd0, dep_stall}, 16'd0);
        chk("mrst.v_de_br_stall", {15'd0, v_de_br_stall}, 16'd0);
        chk_agex("mrst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0);
        $display("mid-run reset: agex_v=%b agex_cc=%b", agex_v, agex_cc);
        idle_inputs();
        tick();
        reset = 1'b0;
        load_de(16'h16C3, 16'h3400, 1'b1);
        ld_agex = 1'b1;
        tick();
        idle_inputs();
        chk_agex("post_rst", 16'h3400, 16'h16C3, 16'h0000, 16'h0000, 3'b010, 3'd3, 1'b1, 1'b1, 1'b1);
        $display("post-reset ADD R3,R3,R3: agex_sr1=%h agex_cc=%b", agex_sr1, agex_cc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
